// File: rtl/pulse_pattern_checker_pkg.sv
// Shared types and defaults for the pulse generator / checker pair.
package pulse_pkg;

   localparam int unsigned DEF_PAT_W        = 16;
   localparam int unsigned DEF_CNT_W        = 16;
   localparam int unsigned DEF_ERR_THRESH   = 2;
   localparam int unsigned DEF_SEARCH_LIMIT = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_SEARCH = 2'd2,
      ST_LOCKED = 2'd3
   } state_e;

   // Bits needed to hold any value in 0..max_val.
   function automatic int unsigned cnt_bits(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pulse_pattern_checker_window.sv
// Serial shift window with equality compare of the post-shift value against the pattern.
module pattern_window
   import pulse_pkg::*;
#(
   parameter int unsigned PAT_W = DEF_PAT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             bit_in,
   input  logic [PAT_W-1:0] pat,
   output logic             match,
   output logic [PAT_W-1:0] window
);

   logic [PAT_W-1:0] window_q;
   logic [PAT_W-1:0] window_d;

   assign window_d = {window_q[PAT_W-2:0], bit_in};
   assign match    = (window_d == pat);
   assign window   = window_q;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         window_q <= '0;
      end else if (shift_en) begin
         window_q <= window_d;
      end
   end

endmodule

// File: rtl/pulse_pattern_checker.sv
// Aligns to the generator's serial pattern stream and checks every bit once locked,
// reporting lock, per-bit errors, a search timeout and error/frame counters.
module pulse_pattern_checker
   import pulse_pkg::*;
#(
   parameter int unsigned PAT_W        = DEF_PAT_W,
   parameter int unsigned ERR_THRESH   = DEF_ERR_THRESH,
   parameter int unsigned SEARCH_LIMIT = DEF_SEARCH_LIMIT,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_flag,
   input  logic [PAT_W-1:0] pattern,
   input  logic             serial_in,
   output logic             locked,
   output logic             bit_error,
   output logic             search_timeout,
   output logic [CNT_W-1:0] error_count,
   output logic [CNT_W-1:0] frame_count
);

   localparam int unsigned IDX_W  = cnt_bits(PAT_W - 1);
   localparam int unsigned FERR_W = cnt_bits(PAT_W);
   localparam int unsigned SCNT_W = cnt_bits(SEARCH_LIMIT);

   state_e             state_q;
   logic [PAT_W-1:0]   pat_q;
   logic [IDX_W-1:0]   fill_cnt_q;
   logic [IDX_W-1:0]   bit_idx_q;
   logic [FERR_W-1:0]  frame_err_q;
   logic [SCNT_W-1:0]  search_cnt_q;
   logic               locked_q;
   logic               bit_error_q;
   logic               timeout_q;
   logic [CNT_W-1:0]   err_cnt_q;
   logic [CNT_W-1:0]   frame_cnt_q;

   logic               win_match;
   logic [PAT_W-1:0]   window_w;
   logic               window_unused;

   logic               mismatch;
   logic [FERR_W-1:0]  frame_err_d;
   logic [CNT_W-1:0]   err_cnt_d;
   logic [SCNT_W-1:0]  search_cnt_d;
   logic [IDX_W-1:0]   bit_idx_d;
   logic               frame_end;
   logic               frame_bad;
   logic               search_expired;

   pattern_window #(
      .PAT_W (PAT_W)
   ) u_window (
      .clock    (clock),
      .reset    (reset),
      .clear    (load_flag),
      .shift_en (state_q != ST_IDLE),
      .bit_in   (serial_in),
      .pat      (pat_q),
      .match    (win_match),
      .window   (window_w)
   );

   // The raw window is observation-only at this level.
   assign window_unused = ^window_w;

   assign mismatch       = (serial_in != pat_q[bit_idx_q]);
   assign frame_err_d    = frame_err_q + FERR_W'(mismatch);
   assign err_cnt_d      = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);
   assign search_cnt_d   = (search_cnt_q == SCNT_W'(SEARCH_LIMIT)) ? search_cnt_q
                                                                   : search_cnt_q + SCNT_W'(1);
   assign bit_idx_d      = (bit_idx_q == '0) ? IDX_W'(PAT_W - 1) : bit_idx_q - IDX_W'(1);
   assign frame_end      = (bit_idx_q == '0);
   assign frame_bad      = (32'(frame_err_d) > ERR_THRESH);
   assign search_expired = ((32'(search_cnt_q) + 32'd1) >= SEARCH_LIMIT);

   // Alignment / checking FSM with all counters and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pat_q        <= '0;
         fill_cnt_q   <= '0;
         bit_idx_q    <= '0;
         frame_err_q  <= '0;
         search_cnt_q <= '0;
         locked_q     <= 1'b0;
         bit_error_q  <= 1'b0;
         timeout_q    <= 1'b0;
         err_cnt_q    <= '0;
         frame_cnt_q  <= '0;
      end else if (load_flag) begin
         state_q      <= ST_FILL;
         pat_q        <= pattern;
         fill_cnt_q   <= '0;
         bit_idx_q    <= '0;
         frame_err_q  <= '0;
         search_cnt_q <= '0;
         locked_q     <= 1'b0;
         bit_error_q  <= 1'b0;
         timeout_q    <= 1'b0;
         err_cnt_q    <= '0;
         frame_cnt_q  <= '0;
      end else begin
         bit_error_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_IDLE;
            end
            ST_FILL: begin
               fill_cnt_q <= fill_cnt_q + IDX_W'(1);
               if (fill_cnt_q == IDX_W'(PAT_W - 1)) begin
                  state_q <= ST_SEARCH;
               end
            end
            ST_SEARCH: begin
               if (win_match) begin
                  state_q      <= ST_LOCKED;
                  locked_q     <= 1'b1;
                  bit_idx_q    <= IDX_W'(PAT_W - 1);
                  frame_err_q  <= '0;
                  search_cnt_q <= '0;
               end else begin
                  search_cnt_q <= search_cnt_d;
                  if (search_expired) begin
                     timeout_q <= 1'b1;
                  end
               end
            end
            ST_LOCKED: begin
               if (mismatch) begin
                  bit_error_q <= 1'b1;
                  err_cnt_q   <= err_cnt_d;
               end
               bit_idx_q <= bit_idx_d;
               if (frame_end) begin
                  frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                  frame_err_q <= '0;
                  // Threshold includes an error on the frame's last bit.
                  if (frame_bad) begin
                     state_q      <= ST_SEARCH;
                     locked_q     <= 1'b0;
                     search_cnt_q <= '0;
                  end
               end else begin
                  frame_err_q <= frame_err_d;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign locked         = locked_q;
   assign bit_error      = bit_error_q;
   assign search_timeout = timeout_q;
   assign error_count    = err_cnt_q;
   assign frame_count    = frame_cnt_q;

endmodule

// File: tb/tb_pulse_pattern_checker.sv
// Directed + randomized bench for pulse_pattern_checker against a bit-history reference model.
module tb_pulse_pattern_checker;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_flag;
   logic [15:0] pattern;
   logic        serial_in;

   logic        locked,  bit_error,  search_timeout;
   logic [15:0] error_count, frame_count;
   logic        locked4, bit_error4, search_timeout4;
   logic [3:0]  error_count4, frame_count4;

   always #5 clock = ~clock;

   pulse_pattern_checker u_dut (
      .clock          (clock),
      .reset          (reset),
      .load_flag      (load_flag),
      .pattern        (pattern),
      .serial_in      (serial_in),
      .locked         (locked),
      .bit_error      (bit_error),
      .search_timeout (search_timeout),
      .error_count    (error_count),
      .frame_count    (frame_count)
   );

   pulse_pattern_checker #(.CNT_W(4)) u_dut4 (
      .clock          (clock),
      .reset          (reset),
      .load_flag      (load_flag),
      .pattern        (pattern),
      .serial_in      (serial_in),
      .locked         (locked4),
      .bit_error      (bit_error4),
      .search_timeout (search_timeout4),
      .error_count    (error_count4),
      .frame_count    (frame_count4)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: counts bits since load, keeps the last 16 received bits,
   // and tracks frame position / error totals as unbounded integers.
   bit          m_active = 0;
   bit          m_locked = 0;
   bit          m_timeout = 0;
   bit          m_biterr = 0;
   int          m_seen = 0;
   int          m_pos = 0;
   int          m_ferr = 0;
   int          m_scnt = 0;
   int          m_err = 0;
   int          m_frames = 0;
   logic [15:0] m_pat = '0;
   logic [15:0] m_hist = '0;

   logic [15:0] cur_pat = '0;
   int          bits_since_load = 0;
   int          lock_at = -1;
   int          to_at = -1;
   int          pulse_cnt = 0;
   bit          prev_locked = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clock(input logic r, input logic ld, input logic [15:0] p, input logic b);
      m_biterr = 0;
      if (r) begin
         m_active = 0; m_locked = 0; m_timeout = 0; m_err = 0; m_frames = 0;
      end else if (ld) begin
         m_active = 1; m_pat = p; m_hist = '0; m_seen = 0; m_locked = 0; m_timeout = 0;
         m_err = 0; m_frames = 0; m_ferr = 0; m_scnt = 0; m_pos = 0;
      end else if (m_active) begin
         m_hist = {m_hist[14:0], b};
         m_seen++;
         if (!m_locked) begin
            if (m_seen > 16) begin
               if (m_hist == m_pat) begin
                  m_locked = 1; m_pos = 0; m_ferr = 0; m_scnt = 0;
               end else begin
                  m_scnt++;
                  if (m_scnt >= 64) m_timeout = 1;
               end
            end
         end else begin
            if (b != m_pat[15 - m_pos]) begin
               m_biterr = 1; m_err++; m_ferr++;
            end
            if (m_pos == 15) begin
               m_frames++;
               if (m_ferr > 2) begin
                  m_locked = 0; m_scnt = 0;
               end
               m_ferr = 0;
               m_pos = 0;
            end else begin
               m_pos++;
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic ld, input logic [15:0] p, input logic b);
      reset = r; load_flag = ld; pattern = p; serial_in = b;
      @(posedge clock);
      model_clock(r, ld, p, b);
      #1;
      if (r || ld) bits_since_load = 0;
      else bits_since_load++;
      check("locked",       locked,         m_locked);
      check("bit_error",    bit_error,      m_biterr);
      check("timeout",      search_timeout, m_timeout);
      check("err_cnt16",    error_count,    32'((m_err > 65535) ? 65535 : m_err));
      check("frame_cnt16",  frame_count,    32'(m_frames % 65536));
      check("locked4",      locked4,        m_locked);
      check("bit_error4",   bit_error4,     m_biterr);
      check("timeout4",     search_timeout4, m_timeout);
      check("err_cnt4",     error_count4,   32'((m_err > 15) ? 15 : m_err));
      check("frame_cnt4",   frame_count4,   32'(m_frames % 16));
      if (locked && !prev_locked && lock_at < 0) lock_at = bits_since_load;
      if (search_timeout && to_at < 0) to_at = bits_since_load;
      if (bit_error) pulse_cnt++;
      prev_locked = locked;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 16'($urandom), 1'b1);
   endtask

   task automatic do_load(input logic [15:0] p);
      cur_pat = p;
      step(1'b0, 1'b1, p, 1'b1);
      lock_at = -1; to_at = -1; pulse_cnt = 0;
   endtask

   task automatic send_bit(input logic b);
      step(1'b0, 1'b0, 16'($urandom), b);
   endtask

   task automatic send_frame(input logic [15:0] p, input logic [15:0] flip);
      for (int i = 15; i >= 0; i--) send_bit(p[i] ^ flip[i]);
   endtask

   initial begin
      logic [15:0] garbage;
      logic [15:0] mask;
      logic [15:0] rp;

      reset = 1'b1; load_flag = 1'b0; pattern = '0; serial_in = 1'b0;
      do_reset();
      do_reset();
      check("rst_locked", locked, 0);
      check("rst_err", error_count, 0);

      // Aligned stream: window fills on bits 1..16, first full pattern re-appears at bit 32.
      do_load(16'hA5C3);
      for (int f = 0; f < 7; f++) send_frame(16'hA5C3, 16'h0000);
      check("aligned_lock_at", lock_at, 32);
      check("aligned_frames", frame_count, 5);
      check("aligned_errs", error_count, 0);
      check("aligned_pulses", pulse_cnt, 0);

      // Misaligned start with 5 garbage bits.
      do_load(16'hA5C3);
      garbage = 16'b10110;
      for (int i = 4; i >= 0; i--) send_bit(garbage[i]);
      for (int f = 0; f < 3; f++) send_frame(16'hA5C3, 16'h0000);
      check("misalign_lock_at", lock_at, 21);
      check("misalign_timeout", search_timeout, 0);

      // One error keeps lock; three errors drop it; clean frames relock.
      pulse_cnt = 0;
      mask = 16'(1) << $urandom_range(0, 15);
      send_frame(16'hA5C3, mask);
      check("inj1_pulses", pulse_cnt, 1);
      check("inj1_errs", error_count, 1);
      check("inj1_locked", locked, 1);
      mask = (16'(1) << $urandom_range(0, 4)) | (16'(1) << $urandom_range(5, 9))
           | (16'(1) << $urandom_range(10, 15));
      send_frame(16'hA5C3, mask);
      check("inj3_locked", locked, 0);
      check("inj3_errs", error_count, 4);
      send_frame(16'hA5C3, 16'h0000);
      send_frame(16'hA5C3, 16'h0000);
      check("relock", locked, 1);

      // Search timeout after 16 fill + 64 search cycles.
      do_load(16'hA5C3);
      for (int i = 0; i < 100; i++) send_bit(1'b0);
      check("timeout_at", to_at, 80);
      check("timeout_set", search_timeout, 1);
      do_load(16'hA5C3);
      check("timeout_cleared", search_timeout, 0);

      // Saturation / wrap with one error per frame.
      do_load(16'hA5C3);
      send_frame(16'hA5C3, 16'h0000);
      send_frame(16'hA5C3, 16'h0000);
      for (int f = 0; f < 20; f++) send_frame(16'hA5C3, 16'(1) << $urandom_range(0, 15));
      check("sat_err4", error_count4, 15);
      check("wrap_frames4", frame_count4, 4);
      check("sat_err16", error_count, 20);
      check("wrap_frames16", frame_count, 20);
      check("sat_locked", locked, 1);

      // Reset while locked, then idle bits are ignored.
      do_reset();
      check("midrst_locked", locked, 0);
      check("midrst_frames", frame_count, 0);
      for (int i = 0; i < 20; i++) send_bit(1'($urandom));
      check("idle_locked", locked, 0);

      // New load while locked switches pattern.
      do_load(16'hA5C3);
      send_frame(16'hA5C3, 16'h0000);
      send_frame(16'hA5C3, 16'h0000);
      send_frame(16'hA5C3, 16'h0000);
      do_load(16'h00FF);
      check("reload_locked", locked, 0);
      check("reload_frames", frame_count, 0);
      for (int f = 0; f < 4; f++) send_frame(16'h00FF, 16'h0000);
      check("reload_lock_at", lock_at, 32);
      check("reload_locked_end", locked, 1);

      // load_flag held high re-captures; all-ones pattern locks right after the fill.
      step(1'b0, 1'b1, 16'($urandom), 1'b1);
      step(1'b0, 1'b1, 16'($urandom), 1'b0);
      do_load(16'hFFFF);
      for (int i = 0; i < 20; i++) send_bit(1'b1);
      check("ones_lock_at", lock_at, 17);

      // Randomized patterns, offsets and error masks.
      for (int it = 0; it < 8; it++) begin
         rp = 16'($urandom);
         do_load(rp);
         for (int i = 0; i < int'($urandom_range(0, 15)); i++) send_bit(1'($urandom));
         for (int f = 0; f < 8; f++) begin
            mask = '0;
            for (int k = 0; k < int'($urandom_range(0, 4)); k++)
               mask = mask | (16'(1) << $urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) mask = '0;
            send_frame(rp, mask);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
